speaker_arbiter: RTL

- Shares the single board speaker pin between up to N_REQ sound sources, e.g. ambulance siren, alarm beep, UI click.
- Each source presents a request and a live square-wave half-period, in clock cycles, such as a siren's sweeping tone value.
- The block grants one source at a time with fixed priority, a minimum hold time and an audible silence gap on every hand-over.
- It generates the speaker square wave from the granted source's half-period and sits between the sound generators and the top-level speaker output.

---
 rtl/sound_pkg.sv | 10 +
 rtl/tone_divider.sv | 30 +++
 rtl/speaker_arbiter.sv | 81 ++++++++
 3 files changed

// File: rtl/sound_pkg.sv
// sound_pkg: arbiter state encoding, default timing constants and tone helper
package sound_pkg;
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
  localparam int DEF_MIN_HOLD = 1000000;
  localparam int DEF_GAP_CYCLES = 100000;
  localparam int CLK_HZ = 100000000;
  function automatic logic [23:0] hp_from_hz(input int hz);
    return (hz <= 0) ? 24'd0 : 24'(CLK_HZ / (2 * hz));
  endfunction
endpackage

// File: rtl/tone_divider.sv
// tone_divider: square wave with live half-period, cleared while disabled
module tone_divider #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] hp,
  output logic             speaker
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic spk_q, spk_d;
  logic run, wrap;
  always_comb begin
    run = en && hp != '0;
    wrap = cnt_q >= hp - 1'b1;
    cnt_d = (!run || wrap) ? '0 : cnt_q + 1'b1;
    spk_d = !run ? 1'b0 : wrap ? ~spk_q : spk_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      spk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      spk_q <= spk_d;
    end
  end
  assign speaker = spk_q;
endmodule

// File: rtl/speaker_arbiter.sv
// speaker_arbiter: fixed-priority speaker sharing with minimum hold, silence gap and tone output
module speaker_arbiter
  import sound_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DIV_W = 24,
  parameter int MIN_HOLD = DEF_MIN_HOLD,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int CNT_W = 24,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*DIV_W-1:0] half_period,
  output logic [N_REQ-1:0]       grant,
  output logic [IDX_W-1:0]       active_idx,
  output logic                   busy,
  output logic                   speaker
);
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(MIN_HOLD);
  localparam logic [CNT_W-1:0] GAP_INIT = CNT_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0);
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, win;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] hi_mask;
  logic play_en;
  always_comb begin
    win = '0;
    for (int i = N_REQ - 1; i >= 0; i--) win = req[i] ? IDX_W'(i) : win;
  end
  assign hi_mask = (N_REQ'(1) << idx_q) - N_REQ'(1);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (|req) begin
        state_d = PLAY;
        idx_d = win;
        cnt_d = HOLD_INIT;
      end
      PLAY: if (!req[idx_q] || (cnt_q == '0 && |(req & hi_mask))) begin
        state_d = GAP;
        cnt_d = GAP_INIT;
      end else cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
      GAP: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      else if (|req) begin
        state_d = PLAY;
        idx_d = win;
        cnt_d = HOLD_INIT;
      end else begin
        state_d = IDLE;
        idx_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end
  assign play_en = state_q == PLAY && state_d == PLAY;
  assign grant = (state_q == PLAY) ? N_REQ'(1) << idx_q : '0;
  assign active_idx = idx_q;
  assign busy = state_q != IDLE;
  tone_divider #(.DIV_W(DIV_W)) u_tone (
    .clk(clk),
    .rst_n(rst_n),
    .en(play_en),
    .hp(half_period[idx_q*DIV_W +: DIV_W]),
    .speaker(speaker)
  );
endmodule
